// File: rtl/bitbrick_fusion_pkg.sv
// Shared definitions for the bitbrick fusion sequencer: precision encodings,
// FSM states, bitbrick mode and chunk/magnitude helpers.
package bitbrick_fusion_pkg;

    localparam logic [1:0] PREC_2B = 2'b00;
    localparam logic [1:0] PREC_4B = 2'b01;
    localparam logic [1:0] PREC_8B = 2'b10;

    // The bitbrick always multiplies magnitudes; sign is restored after fusion.
    localparam logic [1:0] BB_SEL_UNSIGNED = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        FIN  = 2'b10,
        OUT  = 2'b11
    } state_e;

    // Number of 2-bit chunks per operand; encoding 11 behaves like 8b.
    function automatic logic [2:0] n_chunks(input logic [1:0] prec);
        case (prec)
            PREC_2B: n_chunks = 3'd1;
            PREC_4B: n_chunks = 3'd2;
            default: n_chunks = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] prec_mask(input logic [1:0] prec);
        case (prec)
            PREC_2B: prec_mask = 8'h03;
            PREC_4B: prec_mask = 8'h0F;
            default: prec_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic sign_of(input logic [7:0] val, input logic [1:0] prec);
        case (prec)
            PREC_2B: sign_of = val[1];
            PREC_4B: sign_of = val[3];
            default: sign_of = val[7];
        endcase
    endfunction

    // PREC-bit magnitude; the most negative value maps to 2^(PREC-1), which
    // still fits unsigned in PREC bits.
    function automatic logic [7:0] magnitude(input logic [7:0] val,
                                             input logic [1:0] prec,
                                             input logic       is_signed);
        logic [7:0] mask;
        logic [7:0] v;
        mask = prec_mask(prec);
        v    = val & mask;
        if (is_signed && sign_of(v, prec)) begin
            magnitude = (~v + 8'd1) & mask;
        end else begin
            magnitude = v;
        end
    endfunction

endpackage

// File: rtl/bitbrick_fusion_seq_chunk.sv
// bb_chunk_seq: walks the (i, j) chunk pairs, a-chunk i inner and w-chunk j
// outer, and reports the shift-add weight 2(i+j) of the current pair.
module bb_chunk_seq
    import bitbrick_fusion_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       step_i,
    input  logic [2:0] n_i,
    output logic [1:0] i_o,
    output logic [1:0] j_o,
    output logic [3:0] shift_o,
    output logic       last_pair_o
);

    logic [1:0] i_q, i_d;
    logic [1:0] j_q, j_d;
    logic       i_wrap;

    assign i_wrap      = ({1'b0, i_q} == n_i - 3'd1);
    assign last_pair_o = i_wrap && ({1'b0, j_q} == n_i - 3'd1);
    assign shift_o     = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};
    assign i_o         = i_q;
    assign j_o         = j_q;

    // Next chunk pair: restart on start, otherwise advance i and carry into j.
    always_comb begin
        // NOTE: defaults assigned first so no branch leaves a latch behind.
        i_d = i_q;
        j_d = j_q;
        if (start_i) begin
            i_d = 2'd0;
            j_d = 2'd0;
        end else if (step_i) begin
            if (i_wrap) begin
                i_d = 2'd0;
                j_d = j_q + 2'd1;
            end else begin
                i_d = i_q + 2'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            i_q <= 2'd0;
            j_q <= 2'd0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

endmodule

// File: rtl/bitbrick_fusion_seq.sv
// bitbrick_fusion_seq: temporal fusion of 2/4/8-bit products over one 2-bit
// bitbrick, accumulated into a signed dot product.
// Optional feature: define BITBRICK_FUSION_SAT_EN for a saturating accumulator
// with a sticky out_sat flag; otherwise the accumulator wraps.
module bitbrick_fusion_seq
    import bitbrick_fusion_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_w,
    input  logic [1:0]       in_prec,
    input  logic             in_signed,
    input  logic             in_last,
    output logic [1:0]       bb_a,
    output logic [1:0]       bb_w,
    output logic [1:0]       bb_sel,
    input  logic [3:0]       bb_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat
);

    state_e           state_q;
    logic [7:0]       a_mag_q;
    logic [7:0]       w_mag_q;
    logic             neg_q;
    logic [1:0]       prec_q;
    logic             last_q;
    logic [15:0]      prod_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;

    logic [1:0]       ci, cj;
    logic [3:0]       shift;
    logic             last_pair;
    logic             accept;

    assign accept    = (state_q == IDLE) && in_valid;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_acc   = acc_q;
    assign out_sat   = sat_q;
    assign bb_sel    = BB_SEL_UNSIGNED;
    assign bb_a      = (state_q == MUL) ? a_mag_q[{ci, 1'b0} +: 2] : 2'b00;
    assign bb_w      = (state_q == MUL) ? w_mag_q[{cj, 1'b0} +: 2] : 2'b00;

    bb_chunk_seq u_chunk (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (accept),
        .step_i      (state_q == MUL),
        .n_i         (n_chunks(prec_q)),
        .i_o         (ci),
        .j_o         (cj),
        .shift_o     (shift),
        .last_pair_o (last_pair)
    );

    // Signed product merged into the accumulator, wrapping or clamping.
    always_comb begin
        logic [ACC_W-1:0] p_ext;
        logic [ACC_W-1:0] p_signed;
`ifdef BITBRICK_FUSION_SAT_EN
        logic [ACC_W:0]   sum;
`endif
        p_ext    = ACC_W'(prod_q);
        p_signed = neg_q ? (~p_ext + 1'b1) : p_ext;
`ifdef BITBRICK_FUSION_SAT_EN
        sum   = {acc_q[ACC_W-1], acc_q} + {p_signed[ACC_W-1], p_signed};
        acc_d = sum[ACC_W-1:0];
        sat_d = sat_q;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
            sat_d = 1'b1;
        end
`else
        acc_d = acc_q + p_signed;
        sat_d = 1'b0;
`endif
    end

    // Control FSM and datapath registers: accept, shift-add, fold, release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_mag_q <= 8'd0;
            w_mag_q <= 8'd0;
            neg_q   <= 1'b0;
            prec_q  <= PREC_2B;
            last_q  <= 1'b0;
            prod_q  <= 16'd0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // in_signed only matters here; it is folded into the
                        // magnitudes and the product sign.
                        a_mag_q <= magnitude(in_a, in_prec, in_signed);
                        w_mag_q <= magnitude(in_w, in_prec, in_signed);
                        neg_q   <= in_signed &&
                                   (sign_of(in_a, in_prec) ^ sign_of(in_w, in_prec));
                        prec_q  <= in_prec;
                        last_q  <= in_last;
                        prod_q  <= 16'd0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    prod_q <= prod_q + ({12'd0, bb_p} << shift);
                    if (last_pair) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    acc_q   <= acc_d;
                    sat_q   <= sat_d;
                    state_q <= last_q ? OUT : IDLE;
                end
                OUT: begin
                    if (out_ready) begin
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitbrick_fusion_seq.sv
// Directed bench for bitbrick_fusion_seq. A 24-bit and a 16-bit accumulator
// instance run in lockstep on the same stimulus; each has its own bitbrick model.
module tb_bitbrick_fusion_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_signed, in_last, out_ready;
    logic [7:0]  in_a, in_w;
    logic [1:0]  in_prec;

    logic        in_ready, out_valid, out_sat;
    logic [1:0]  bb_a, bb_w, bb_sel;
    logic [3:0]  bb_p;
    logic [23:0] out_acc;

    logic        in_ready16, out_valid16, out_sat16;
    logic [1:0]  bb_a16, bb_w16, bb_sel16;
    logic [3:0]  bb_p16;
    logic [15:0] out_acc16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Bitbrick models: unsigned 2b x 2b, combinational.
    assign bb_p   = {2'b00, bb_a} * {2'b00, bb_w};
    assign bb_p16 = {2'b00, bb_a16} * {2'b00, bb_w16};

    bitbrick_fusion_seq #(.ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_w(in_w), .in_prec(in_prec), .in_signed(in_signed),
        .in_last(in_last), .bb_a(bb_a), .bb_w(bb_w), .bb_sel(bb_sel), .bb_p(bb_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_sat(out_sat)
    );

    bitbrick_fusion_seq #(.ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .in_a(in_a), .in_w(in_w), .in_prec(in_prec), .in_signed(in_signed),
        .in_last(in_last), .bb_a(bb_a16), .bb_w(bb_w16), .bb_sel(bb_sel16),
        .bb_p(bb_p16), .out_valid(out_valid16), .out_ready(out_ready),
        .out_acc(out_acc16), .out_sat(out_sat16)
    );

    // Handshake one operand pair; returns just after the accept edge E0.
    task automatic send(input logic [7:0] a, input logic [7:0] w,
                        input logic [1:0] p, input logic s, input logic l);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        in_a = a; in_w = w; in_prec = p; in_signed = s; in_last = l;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_w = 8'($urandom);
        in_last = 1'($urandom);
    endtask

    // Edges after the accept edge until out_valid (capped at 40).
    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_w = 8'd0;
        in_prec = 2'b00; in_signed = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_acc !== 24'd0) begin errors++; $display("FAIL rst_out_acc got %0h exp 0", out_acc); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat got %0b exp 0", out_sat); end
        checks++; if ({bb_a, bb_w} !== 4'b0000) begin errors++; $display("FAIL rst_bb_aw got %b exp 0000", {bb_a, bb_w}); end
        checks++; if (bb_sel !== 2'b01) begin errors++; $display("FAIL rst_bb_sel got %b exp 01", bb_sel); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_idle got rdy=%0b vld=%0b exp 1/0", in_ready, out_valid); end
    endtask

    // -128 x -128 in 8b signed: |a| = |w| = 0x80, only chunk 3 is nonzero (10b).
    task automatic test_8b_signed();
        logic [7:0] mag = 8'd128;
        logic [1:0] ea, ew;
        send(8'h80, 8'h80, 2'b10, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            ea = 2'(mag >> (2 * (k % 4)));
            ew = 2'(mag >> (2 * (k / 4)));
            checks++; if (bb_a !== ea || bb_w !== ew) begin errors++; $display("FAIL 8b_chunk%0d got a=%b w=%b exp a=%b w=%b", k, bb_a, bb_w, ea, ew); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL 8b_ready_mul%0d got %0b exp 0", k, in_ready); end
            @(posedge clk); #1;
        end
        checks++; if ({bb_a, bb_w} !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL 8b_fin got bb=%b vld=%0b exp 0000/0", {bb_a, bb_w}, out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL 8b_latency17 got vld=%0b exp 1", out_valid); end
        checks++; if (out_acc !== 24'd16384) begin errors++; $display("FAIL 8b_acc got %0d exp 16384", $signed(out_acc)); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL 8b_sat got %0b exp 0", out_sat); end
        take_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL 8b_release got vld=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
    endtask

    task automatic test_4b_unsigned();
        int edges = 0;
        int bad_sel = 0;
        send(8'h0F, 8'h0F, 2'b01, 1'b0, 1'b1);
        while (!out_valid && edges < 40) begin
            if (bb_sel !== 2'b01) bad_sel++;
            @(posedge clk); #1; edges++;
        end
        checks++; if (bad_sel != 0) begin errors++; $display("FAIL 4b_bb_sel got %0d bad cycles exp 0", bad_sel); end
        checks++; if (edges != 5) begin errors++; $display("FAIL 4b_latency got %0d exp 5", edges); end
        checks++; if (out_acc !== 24'd225) begin errors++; $display("FAIL 4b_acc got %0d exp 225", $signed(out_acc)); end
        take_out();
    endtask

    // (-2 x 1) + (1 x 1) in 2b signed = -1; upper input bits must be ignored.
    task automatic test_2b_dot();
        int edges;
        send(8'hFE, 8'h01, 2'b00, 1'b1, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL 2b_ready_mul got %0b exp 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL 2b_ready_fin got %0b exp 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL 2b_mid_idle got rdy=%0b vld=%0b exp 1/0", in_ready, out_valid); end
        send(8'h01, 8'hFD, 2'b00, 1'b1, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL 2b_ready_mul2 got %0b exp 0", in_ready); end
        wait_out(edges);
        checks++; if (edges != 2) begin errors++; $display("FAIL 2b_latency got %0d exp 2", edges); end
        checks++; if (out_acc !== 24'hFFFFFF) begin errors++; $display("FAIL 2b_acc got %0d exp -1", $signed(out_acc)); end
        take_out();
    endtask

    task automatic test_backpressure();
        int edges;
        send(8'd5, 8'd6, 2'b01, 1'b0, 1'b1);
        wait_out(edges);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_a = 8'($urandom); in_w = 8'($urandom);
            checks++; if (out_valid !== 1'b1 || out_acc !== 24'd30 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got vld=%0b acc=%0d rdy=%0b exp 1/30/0", k, out_valid, $signed(out_acc), in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        take_out();
        send(8'd3, 8'd3, 2'b01, 1'b0, 1'b1);
        wait_out(edges);
        checks++; if (out_acc !== 24'd9) begin errors++; $display("FAIL bp_restart got %0d exp 9", $signed(out_acc)); end
        take_out();
    endtask

    // A pending partial sum of 9 must be discarded by the reset.
    task automatic test_reset_mid_mul();
        int edges;
        send(8'd3, 8'd3, 2'b01, 1'b0, 1'b0);
        send(8'h7F, 8'h7F, 2'b10, 1'b1, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_mul got rdy=%0b exp 0", in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 24'd0 || out_sat !== 1'b0 || {bb_a, bb_w} !== 4'b0000) begin
            errors++; $display("FAIL rmid_async got rdy=%0b vld=%0b acc=%0h sat=%0b bb=%b exp 1/0/0/0/0000", in_ready, out_valid, out_acc, out_sat, {bb_a, bb_w});
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_next got rdy=%0b vld=%0b exp 1/0", in_ready, out_valid); end
        send(8'd1, 8'd1, 2'b00, 1'b0, 1'b1);
        wait_out(edges);
        checks++; if (edges != 2 || out_acc !== 24'd1) begin errors++; $display("FAIL rmid_after got edges=%0d acc=%0d exp 2/1", edges, $signed(out_acc)); end
        take_out();
    endtask

    // Two 16384 products sum to 32768: fits in 24 bits, overflows 16 bits.
    task automatic test_saturation();
        int edges;
        logic [15:0] exp16;
        logic        exp_sat16;
`ifdef BITBRICK_FUSION_SAT_EN
        exp16 = 16'h7FFF; exp_sat16 = 1'b1;
`else
        exp16 = 16'h8000; exp_sat16 = 1'b0;
`endif
        send(8'h80, 8'h80, 2'b10, 1'b1, 1'b0);
        send(8'h80, 8'h80, 2'b10, 1'b1, 1'b1);
        wait_out(edges);
        checks++; if (out_valid16 !== 1'b1) begin errors++; $display("FAIL sat_valid16 got %0b exp 1", out_valid16); end
        checks++; if (out_acc16 !== exp16) begin errors++; $display("FAIL sat_acc16 got %0h exp %0h", out_acc16, exp16); end
        checks++; if (out_sat16 !== exp_sat16) begin errors++; $display("FAIL sat_flag16 got %0b exp %0b", out_sat16, exp_sat16); end
        checks++; if (out_acc !== 24'd32768 || out_sat !== 1'b0) begin errors++; $display("FAIL sat_acc24 got %0d sat=%0b exp 32768/0", $signed(out_acc), out_sat); end
        take_out();
        checks++; if (out_sat16 !== 1'b0 || out_acc16 !== 16'd0) begin errors++; $display("FAIL sat_clear16 got sat=%0b acc=%0h exp 0/0", out_sat16, out_acc16); end
    endtask

    initial begin
        test_reset();
        test_8b_signed();
        test_4b_unsigned();
        test_2b_dot();
        test_backpressure();
        test_reset_mid_mul();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
